// File: rtl/prog_mem_pkg.sv
// Shared types for the program/data memory controller: FSM states,
// arbiter port selection and the byte-lane helper.
package prog_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_DBG   = 2'd2
  } sel_e;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Single-port synchronous storage with per-byte write enables and a
// registered read port. Contents are intentionally not reset.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic                          we,
  input  logic [byte_lanes(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Two-port memory controller: read-only fetch port and byte-enabled debug
// port sharing one array, with a post-reset clear sequencer and stall input.
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 11,
  parameter int DEPTH          = 2**ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int DBG_BURST_MAX  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          enable_half,
  input  logic                          f_req,
  input  logic [ADDR_W-1:0]             f_addr,
  output logic                          f_gnt,
  output logic                          f_rvalid,
  output logic [DATA_W-1:0]             f_rdata,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [byte_lanes(DATA_W)-1:0] d_be,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          busy
);

  localparam int                LANES     = byte_lanes(DATA_W);
  localparam int                BURST_W   = $clog2(DBG_BURST_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e             state, state_nxt;
  sel_e               sel;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               fetch_wins;
  logic               f_in_range, d_in_range;

  logic               arr_en, arr_we;
  logic [LANES-1:0]   arr_be;
  logic [ADDR_W-1:0]  arr_addr;
  logic [DATA_W-1:0]  arr_wdata, arr_rdata;

  logic               f_rd_q, d_rd_q, oor_q;
  logic [DATA_W-1:0]  f_hold, d_hold, rd_word;

  assign f_in_range = ({1'b0, f_addr} < (ADDR_W+1)'(DEPTH));
  assign d_in_range = ({1'b0, d_addr} < (ADDR_W+1)'(DEPTH));
  assign fetch_wins = (burst_cnt >= BURST_W'(DBG_BURST_MAX));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR_ON_RESET ? CLEAR : RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && !enable_half && clr_cnt == LAST_ADDR) state_nxt = RUN;
  end

  // Debug wins contention unless fetch has already waited out a full burst.
  always_comb begin
    sel       = SEL_NONE;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_addr  = '0;
    arr_wdata = '0;
    busy      = (state == CLEAR);
    case (state)
      CLEAR: begin
        if (!enable_half) begin
          arr_en   = 1'b1;
          arr_we   = 1'b1;
          arr_be   = '1;
          arr_addr = clr_cnt;
        end
      end
      default: begin
        if (Reset_n && !enable_half) begin
          if (d_req && !(f_req && fetch_wins)) sel = SEL_DBG;
          else if (f_req)                      sel = SEL_FETCH;
        end
      end
    endcase
    case (sel)
      SEL_DBG: begin
        arr_en    = d_in_range;
        arr_we    = d_we;
        arr_be    = d_be;
        arr_addr  = d_addr;
        arr_wdata = d_wdata;
      end
      SEL_FETCH: begin
        arr_en   = f_in_range;
        arr_addr = f_addr;
      end
      default: ;
    endcase
    f_gnt = (sel == SEL_FETCH);
    d_gnt = (sel == SEL_DBG);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == CLEAR && !enable_half)
        clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
      if (!f_req || f_gnt)
        burst_cnt <= '0;
      else if (d_gnt && !fetch_wins)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Out-of-range reads never touch the array; the flag forces their data to zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      f_rd_q <= 1'b0;
      d_rd_q <= 1'b0;
      oor_q  <= 1'b0;
      f_hold <= '0;
      d_hold <= '0;
    end else begin
      f_rd_q <= f_gnt;
      d_rd_q <= d_gnt && !d_we;
      oor_q  <= (f_gnt && !f_in_range) || (d_gnt && !d_we && !d_in_range);
      if (f_rd_q) f_hold <= rd_word;
      if (d_rd_q) d_hold <= rd_word;
    end
  end

  assign rd_word  = oor_q ? '0 : arr_rdata;
  assign f_rvalid = f_rd_q;
  assign d_rvalid = d_rd_q;
  assign f_rdata  = f_rd_q ? rd_word : f_hold;
  assign d_rdata  = d_rd_q ? rd_word : d_hold;

  prog_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (Clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl: directed requests push expected read
// data with its due cycle; per-port monitors pop and compare on rvalid.
module tb_prog_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic              enable_half = 1'b0;
  logic              f_req = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic              f_gnt, f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [3:0]        d_be = '0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              busy;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t f_q[$];
  exp_t d_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  prog_mem_ctrl #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1),
    .DBG_BURST_MAX  (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .enable_half (enable_half),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_rvalid    (f_rvalid),
    .f_rdata     (f_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin : f_monitor
    exp_t e;
    if (Reset_n) begin
      if (f_rvalid) begin
        if (f_q.size() == 0) begin
          checkOutput("f_rvalid_unexpected", 32'(f_rvalid), 32'(0));
        end else begin
          e = f_q.pop_front();
          checkOutput("f_rdata", f_rdata, e.data);
          checkOutput("f_rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (f_q.size() != 0 && f_q[0].due <= cyc) begin
        e = f_q.pop_front();
        checkOutput("f_rvalid_missing", 32'(f_rvalid), 32'(1));
      end
    end
  end

  always @(negedge Clk) begin : d_monitor
    exp_t e;
    if (Reset_n) begin
      if (d_rvalid) begin
        if (d_q.size() == 0) begin
          checkOutput("d_rvalid_unexpected", 32'(d_rvalid), 32'(0));
        end else begin
          e = d_q.pop_front();
          checkOutput("d_rdata", d_rdata, e.data);
          checkOutput("d_rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
        e = d_q.pop_front();
        checkOutput("d_rvalid_missing", 32'(d_rvalid), 32'(1));
      end
    end
  end

  // One request on one port, held until granted; reads queue their expected data.
  task automatic applyStimulus(input bit is_dbg, input logic we, input logic [3:0] be,
                               input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rd);
    bit got = 0;
    @(posedge Clk); #1;
    if (is_dbg) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge Clk);
      got = is_dbg ? d_gnt : f_gnt;
    end
    checkOutput(is_dbg ? "d_gnt" : "f_gnt", 32'(got), 32'(1));
    if (got && (!is_dbg || !we)) begin
      if (is_dbg) d_q.push_back('{exp_rd, cyc + 1});
      else        f_q.push_back('{exp_rd, cyc + 1});
    end
    @(posedge Clk); #1;
    d_req = 1'b0;
    f_req = 1'b0;
  endtask

  // Releases reset with debug requesting, counts busy cycles, verifies no grants meanwhile.
  task automatic releaseAndCountBusy(input string tag);
    int cnt = 0;
    bit saw_gnt = 0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0;
    @(negedge Clk);
    while (busy && cnt < 3000) begin
      cnt++;
      if (d_gnt || f_gnt) saw_gnt = 1;
      @(negedge Clk);
    end
    d_req = 1'b0;
    checkOutput({tag, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
    checkOutput({tag, "_no_gnt_in_clear"}, 32'(saw_gnt), 32'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_f_gnt"}, 32'(f_gnt), 32'(0));
    checkOutput({tag, "_d_gnt"}, 32'(d_gnt), 32'(0));
    checkOutput({tag, "_f_rvalid"}, 32'(f_rvalid), 32'(0));
    checkOutput({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(0));
    checkOutput({tag, "_f_rdata"}, f_rdata, 32'h0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(1));
  endtask

  initial begin
    bit exp_f;

    #1 Reset_n = 1'b0;
    #2 checkResetOutputs("rst0");
    releaseAndCountBusy("clr0");

    applyStimulus(1, 0, 4'hF, 11'd0,    32'h0, 32'h0000_0000);
    applyStimulus(1, 0, 4'hF, 11'd1023, 32'h0, 32'h0000_0000);
    applyStimulus(1, 0, 4'hF, 11'd2047, 32'h0, 32'h0000_0000);

    applyStimulus(1, 1, 4'b1111, 11'd5, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1, 1, 4'b0010, 11'd5, 32'h0000_AA00, 32'h0);
    applyStimulus(1, 0, 4'hF,    11'd5, 32'h0,         32'hDEAD_AAEF);

    // Contended reads: expect D D D D F repeating.
    @(posedge Clk); #1;
    f_req = 1'b1; f_addr = 11'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      exp_f = (i % 5 == 4);
      checkOutput("arb_f_gnt", 32'(f_gnt), 32'(exp_f));
      checkOutput("arb_d_gnt", 32'(d_gnt), 32'(!exp_f));
      if (exp_f) f_q.push_back('{32'hDEAD_AAEF, cyc + 1});
      else       d_q.push_back('{32'h0000_0000, cyc + 1});
    end
    @(posedge Clk); #1;
    f_req = 1'b0; d_req = 1'b0;

    applyStimulus(1, 1, 4'hF, 11'd2, 32'hCAFE_F00D, 32'h0);
    @(posedge Clk); #1;
    f_req = 1'b1; f_addr = 11'd2;
    @(negedge Clk);
    checkOutput("stall_first_f_gnt", 32'(f_gnt), 32'(1));
    f_q.push_back('{32'hCAFE_F00D, cyc + 1});
    @(posedge Clk); #1;
    enable_half = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("stall_f_gnt", 32'(f_gnt), 32'(0));
      checkOutput("stall_d_gnt", 32'(d_gnt), 32'(0));
      @(posedge Clk); #1;
    end
    enable_half = 1'b0;
    d_req = 1'b0;
    @(negedge Clk);
    checkOutput("stall_resume_f_gnt", 32'(f_gnt), 32'(1));
    f_q.push_back('{32'hCAFE_F00D, cyc + 1});
    @(posedge Clk); #1;
    f_req = 1'b0;

    @(posedge Clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 11'd100; d_wdata = 32'h1234_5678;
    @(negedge Clk);
    checkOutput("raw_d_gnt", 32'(d_gnt), 32'(1));
    @(posedge Clk); #1;
    d_req = 1'b0;
    f_req = 1'b1; f_addr = 11'd100;
    @(negedge Clk);
    checkOutput("raw_f_gnt", 32'(f_gnt), 32'(1));
    f_q.push_back('{32'h1234_5678, cyc + 1});
    @(posedge Clk); #1;
    f_req = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("f_rdata_hold", f_rdata, 32'h1234_5678);

    applyStimulus(1, 1, 4'b0000, 11'd100, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1, 0, 4'hF,    11'd100, 32'h0,         32'h1234_5678);
    repeat (3) @(negedge Clk);
    checkOutput("d_rdata_hold", d_rdata, 32'h1234_5678);

    // Async reset while holding non-zero read data, then again mid-clear.
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    f_q.delete(); d_q.delete();
    #1 checkResetOutputs("rst1");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (700) @(posedge Clk);
    #2 checkOutput("busy_mid_clear", 32'(busy), 32'(1));
    Reset_n = 1'b0;
    #1 checkResetOutputs("rst2");
    releaseAndCountBusy("clr2");

    applyStimulus(1, 0, 4'hF, 11'd100, 32'h0, 32'h0000_0000);
    applyStimulus(0, 0, 4'h0, 11'd5,   32'h0, 32'h0000_0000);
    repeat (4) @(negedge Clk);
    checkOutput("scoreboard_drained", 32'(f_q.size() + d_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
